// File: rtl/seq_signed_multiplier.sv
// Sequential signed multiplier: shift-and-add over sign-magnitude operands.
// Produces the exact 2*WIDTH product and a FRAC_BITS-dequantized WIDTH-bit result.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (in_ready high only when idle)
//   multiplicand           signed operand A
//   multiplier             signed operand B
//   out_valid / out_ready  result handshake (out_valid high only when done)
//   product_full           exact signed A*B
//   product                low WIDTH bits of (product_full >>> FRAC_BITS)
module seq_signed_multiplier #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product_full,
  output logic [WIDTH-1:0]     product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    mag_a_sh;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]    cnt;
  logic             neg;

  logic [WIDTH-1:0] abs_a_c;
  logic [WIDTH-1:0] abs_b_c;
  logic [PW-1:0]    signed_acc_c;
  logic [PW-1:0]    shifted_c;

  // Handshake decodes of the state register only
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Magnitudes; the most negative value maps to 2^(WIDTH-1), exact as unsigned
  assign abs_a_c = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
  assign abs_b_c = multiplier[WIDTH-1]   ? (~multiplier   + WIDTH'(1)) : multiplier;

  // Negating a zero accumulator yields zero, so no negative-zero result exists
  assign signed_acc_c = neg ? (~acc + PW'(1)) : acc;
  assign shifted_c    = PW'($signed(signed_acc_c) >>> FRAC_BITS);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (in_valid) state_nx = S_MUL;
      S_MUL:  if (cnt == CW'(WIDTH - 1)) state_nx = S_SIGN;
      S_SIGN: state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath: capture, one shift-add step per cycle, sign fix-up into result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      acc          <= '0;
      mag_a_sh     <= '0;
      mag_b        <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
      product_full <= '0;
      product      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mag_a_sh <= PW'(abs_a_c);
            mag_b    <= abs_b_c;
            neg      <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
            acc      <= '0;
            cnt      <= '0;
          end
        end
        S_MUL: begin
          if (mag_b[0]) begin
            acc <= acc + mag_a_sh;
          end
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          cnt      <= cnt + CW'(1);
        end
        S_SIGN: begin
          product_full <= signed_acc_c;
          product      <= shifted_c[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Testbench for seq_signed_multiplier: directed vectors, backpressure, mid-run
// reset and randomized traffic, checked by a scoreboard against an integer model.
module tb_seq_signed_multiplier;

  localparam int unsigned W    = 32;
  localparam int unsigned FRAC = 10;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [W-1:0]    multiplicand = '0;
  logic [W-1:0]    multiplier = '0;
  logic            in_ready, out_valid;
  logic [2*W-1:0]  product_full;
  logic [W-1:0]    product;
  logic            in_ready0, out_valid0;
  logic [2*W-1:0]  product_full0;
  logic [W-1:0]    product0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic prev_ov = 1'b0;

  typedef struct packed {
    logic [2*W-1:0] pf;
    logic [W-1:0]   p;
  } exp_t;
  exp_t sb[$];

  seq_signed_multiplier #(.WIDTH(W), .FRAC_BITS(FRAC)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .multiplicand(multiplicand), .multiplier(multiplier), .out_valid(out_valid),
    .out_ready(out_ready), .product_full(product_full), .product(product)
  );

  // Integer-format build sharing the same stimulus
  seq_signed_multiplier #(.WIDTH(W), .FRAC_BITS(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .multiplicand(multiplicand), .multiplier(multiplier), .out_valid(out_valid0),
    .out_ready(out_ready), .product_full(product_full0), .product(product0)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb_, full;
    sa   = longint'($signed(a));
    sb_  = longint'($signed(b));
    full = sa * sb_;
    e.pf = full;
    e.p  = W'(full >>> FRAC);
    return e;
  endfunction

  // Monitor: at negedge the values seen are exactly what the next rising edge samples
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(model(multiplicand, multiplier));
        acc_cyc <= cyc;
      end
      if (out_valid && !prev_ov) chk("latency", 64'(cyc - acc_cyc), 64'(W + 2));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("product_full", product_full, e.pf);
          chk("product", 64'(product), 64'(e.p));
          chk("frac0_valid", 64'(out_valid0), 64'(1));
          chk("frac0_in_ready", 64'(in_ready0), 64'(0));
          chk("frac0_full", product_full0, e.pf);
          chk("frac0_product", 64'(product0), 64'(e.pf[W-1:0]));
        end
      end
    end
    prev_ov <= out_valid && !reset;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present operands and hold until the acceptance edge has passed
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(0), 64'(1));
    tick(1);
    in_valid     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 300) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0 || !in_ready) chk("drain_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    logic [2*W-1:0] snap_pf;
    logic [W-1:0]   snap_p;
    int n;

    // Reset state
    tick(3);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_product", 64'(product), 64'(0));
    chk("rst_product_full", product_full, 64'(0));
    reset = 1'b0;
    tick(1);
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Directed corner vectors
    send(32'd3072, -32'sd2048);              drain();
    send(32'h8000_0000, 32'hFFFF_FFFF);      drain();
    send(32'h8000_0000, 32'h8000_0000);      drain();
    send(32'hFFFF_FFFF, 32'd1);              drain();
    send(32'd0, -32'sd5);                    drain();
    send(-32'sd5, 32'd0);                    drain();

    // Backpressure in DONE with literal expectations
    out_ready = 1'b0;
    send(32'd3072, -32'sd2048);
    n = 0;
    while (!out_valid && n < 100) begin tick(1); n++; end
    chk("bp_reach_done", 64'(out_valid), 64'(1));
    chk("bp_full_literal", product_full, 64'hFFFF_FFFF_FFA0_0000);
    chk("bp_product_literal", 64'(product), 64'(32'hFFFF_E800));
    snap_pf = product_full;
    snap_p  = product;
    for (int i = 0; i < 10; i++) begin
      in_valid     = i[0];
      multiplicand = $urandom;
      multiplier   = $urandom;
      tick(1);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_hold_full", product_full, snap_pf);
      chk("bp_hold_product", 64'(product), 64'(snap_p));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick(1);
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(out_valid), 64'(0));

    // Reset during the fifth MUL cycle discards the transaction
    send(32'd7, 32'd6);
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_product", 64'(product), 64'(0));
    chk("midrst_product_full", product_full, 64'(0));
    reset = 1'b0;
    tick(1);
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (out_valid) chk("midrst_no_output", 64'(out_valid), 64'(0));
    end
    out_ready = 1'b0;
    send(32'd7, 32'd6);
    n = 0;
    while (!out_valid0 && n < 100) begin tick(1); n++; end
    chk("int_product_42", 64'(product0), 64'(42));
    out_ready = 1'b1;
    drain();

    // Randomized traffic with random gaps and backpressure
    for (int t = 0; t < 1000; t++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h8000_0000;
        2: a = W'($urandom_range(0, 3)) - W'(1);
        3: b = W'($urandom_range(0, 3)) - W'(1);
        default: ;
      endcase
      tick($urandom_range(0, 3));
      send(a, b);
      n = 0;
      while (sb.size() != 0 && n < 500) begin
        out_ready    = 1'($urandom_range(0, 1));
        in_valid     = 1'($urandom_range(0, 1));
        multiplicand = $urandom;
        multiplier   = $urandom;
        tick(1);
        n++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (sb.size() != 0) chk("random_timeout", 64'(sb.size()), 64'(0));
    end
    drain();
    tick(3);
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_signed_multiplier.md
# seq_signed_multiplier

Multi-cycle signed fixed-point multiplier: shift-and-add over sign-magnitude operands, one product per transaction, valid/ready handshakes on both sides. It is the multiplicative counterpart of the signed divider in the datapath. It serves FM demod and filter stages that need a full-width product without a DSP-wide combinational multiply. It outputs the exact 2×WIDTH product and a dequantized WIDTH-bit result.

## Interface
- WIDTH, 32, operand and dequantized-product width (≥ 4)
- FRAC_BITS, 10, fixed-point fraction bits removed from the full product (0 ≤ FRAC_BITS < WIDTH)

- clock  input  1  rising-edge clock; only clock domain
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands (high only in IDLE)
- multiplicand  input  WIDTH  signed two's complement operand A
- multiplier  input  WIDTH  signed two's complement operand B
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  downstream accepts result
- product_full  output  2*WIDTH  exact signed A×B
- product  output  WIDTH  low WIDTH bits of (product_full >>> FRAC_BITS)

## Operation
- States: IDLE, MUL, SIGN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, register the following and go to MUL:
  - mag_a = |A| and mag_b = |B| as WIDTH-bit unsigned. −2^(WIDTH−1) maps to 2^(WIDTH−1), which is exact in unsigned.
  - neg = A[msb]^B[msb].
  - acc = 0 (2*WIDTH bits), cnt = 0.
- MUL: one iteration per cycle.
  - If mag_b[0] then acc += mag_a_shifted.
  - mag_a_shifted <<= 1 (2*WIDTH wide); mag_b >>= 1; cnt++.
  - After the iteration with cnt==WIDTH−1, go to SIGN.
  - No early exit on zero operands; latency is fixed.
- SIGN: product_full <= neg ? −acc : acc; product <= (neg ? −acc : acc) >>> FRAC_BITS, truncated to WIDTH. Go to DONE.
- DONE: out_valid=1. product and product_full are held stable until out_ready. On out_valid&&out_ready go to IDLE.
- Arithmetic:
  - product_full is exact for all inputs, including (−2^(W−1))×(−2^(W−1)) = 2^(2W−2).
  - product uses an arithmetic shift (floor toward −∞), with no rounding and no saturation; overflow wraps in the low WIDTH bits.
  - neg with a zero magnitude yields −0 = 0. The result must never be a nonzero negative from a zero product.
- Inputs are ignored when in_ready=0. A and B need not stay stable after acceptance.

## Timing
- Reset (sampled at a rising edge, any state, any cycle):
  - Next state IDLE; out_valid=0; product=0; product_full=0; acc, cnt and neg cleared.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset during MUL, SIGN or DONE discards the transaction and produces no out_valid pulse.
- Latency: the acceptance edge is edge 0. MUL runs edges 1..WIDTH; SIGN→DONE at edge WIDTH+1. out_valid is first high in the cycle after edge WIDTH+1 (33 edges for WIDTH=32).
- Throughput: with out_ready held high, one result per WIDTH+3 cycles (DONE 1 cycle, IDLE 1 cycle). No overlap of transactions.
- Backpressure: in DONE with out_ready=0, stay indefinitely. Outputs are bit-stable and in_ready=0.
- in_ready is a combinational decode of state==IDLE. out_valid is a decode of state==DONE. Neither depends combinationally on in_valid or out_ready.
- Simultaneous reset and handshake: reset wins; no acceptance, no completion.

## Test plan
- FRAC_BITS=10, A=3072 (3.0), B=−2048 (−2.0) → product_full=−6291456, product=−6144; out_valid exactly WIDTH+1 edges after acceptance edge.
- A=−2^31, B=−1 → product_full=2147483648 (0x0000_0000_8000_0000), product=2097152. Then A=B=−2^31 → product_full=2^62.
- A=−1, B=1 → product_full=−1, product=−1 (floor). A=0, B=−5 → both outputs 0, no negative zero, same latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs unchanged, in_ready=0, in_valid pulses ignored. Release → IDLE next edge, in_ready=1.
- Reset asserted on the 5th MUL cycle → out_valid=0 and outputs 0 after the edge. in_ready=1 after deassert. A following transaction 7×6 (FRAC_BITS=0 build) → product=42 with normal latency.
- Random signed pairs (≥1000, random in_valid/out_ready gaps) against a reference model: exact product_full, floor-shifted product, one output per accepted input, in order.
